// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the write-back sequencer: default datapath width,
// RV32 load funct3 encodings and the sequencer state encoding.
package writeback_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_LOAD_WAIT = 2'd1,
    WB_WRITE     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: picks the addressed byte/halfword out of a read word and
// sign- or zero-extends it. LW and unknown funct3 pass the word through.
module load_align
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      sh,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension; halfword lane uses addr[1] only.
  always_comb begin
    byte_sel = rdata[{sh, 3'b000} +: 8];
    half_sel = rdata[{sh[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: retires one instruction per handshake from execute and
// drives the register-file write port. ALU results are written the cycle
// after accept; loads go through a data-memory request/ack with timeout.
// Optional macro WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wr_en,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_result,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            load_err
`ifdef WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  // Last count value without ack; the edge leaving it is the timeout.
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  wb_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            mem_req_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            load_err_q;

  // Context of the outstanding load
  logic [4:0]      pend_rd;
  logic [2:0]      pend_f3;
  logic [1:0]      pend_sh;
  logic            pend_wr;

  logic            alu_wr;
  logic            ld_issue;
  logic            ld_done;
  logic            ack_wr;
  logic            timeout;
  logic            in_writes;
  logic [XLEN-1:0] aligned;

  assign in_writes = in_wr_en && (in_rd != 5'd0);

  load_align #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rdata),
    .funct3 (pend_f3),
    .sh     (pend_sh),
    .result (aligned)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WB_IDLE;
    else     state_q <= state_d;
  end

  // Next state, accept/completion strobes and status outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    reg_write = 1'b0;
    alu_wr    = 1'b0;
    ld_issue  = 1'b0;
    ld_done   = 1'b0;
    ack_wr    = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      WB_IDLE, WB_WRITE: begin
        in_ready  = 1'b1;
        reg_write = (state_q == WB_WRITE);
        state_d   = WB_IDLE;
        if (in_valid) begin
          if (in_is_load) begin
            ld_issue = 1'b1;
            state_d  = WB_LOAD_WAIT;
          end else if (in_writes) begin
            alu_wr  = 1'b1;
            state_d = WB_WRITE;
          end
        end
      end
      WB_LOAD_WAIT: begin
        // Ack is checked first so an ack in the last cycle still completes
        if (mem_ack) begin
          ld_done = 1'b1;
          ack_wr  = pend_wr;
          state_d = pend_wr ? WB_WRITE : WB_IDLE;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Timeout counter: cleared on issue, counts LOAD_WAIT cycles without ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ld_issue || ld_done || timeout) begin
      cnt_q <= '0;
    end else if (state_q == WB_LOAD_WAIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Memory request and captured load context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pend_rd    <= 5'd0;
      pend_f3    <= 3'd0;
      pend_sh    <= 2'd0;
      pend_wr    <= 1'b0;
    end else if (ld_issue) begin
      mem_req_q  <= 1'b1;
      mem_addr_q <= {in_result[XLEN-1:2], 2'b00};
      pend_rd    <= in_rd;
      pend_f3    <= in_funct3;
      pend_sh    <= in_result[1:0];
      pend_wr    <= in_writes;
    end else if (ld_done || timeout) begin
      mem_req_q  <= 1'b0;
    end
  end

  // Write-port data: only updated when entering WRITE, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
    end else if (alu_wr) begin
      wb_rd_q   <= in_rd;
      wb_data_q <= in_result;
    end else if (ack_wr) begin
      wb_rd_q   <= pend_rd;
      wb_data_q <= aligned;
    end
  end

  // One-cycle abort pulse after the final unacknowledged cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_err_q <= 1'b0;
    else     load_err_q <= timeout;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign load_err = load_err_q;

`ifdef WB_FWD_EN
  assign fwd_valid = reg_write;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;
`endif

endmodule
